// File: rtl/hatch_pkg.sv
// Shared types and constants for the hatch instruction fetch unit.
// Instructions are 48 bits wide and occupy 6 bytes of the fetch address space.
package hatch_pkg;

  localparam int INST_W     = 48;
  localparam int INST_BYTES = 6;
  localparam int ADDR_W     = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Byte address to word index; a constant divide, so this maps to plain logic.
  function automatic logic [ADDR_W-1:0] div6(input logic [ADDR_W-1:0] byte_addr);
    return byte_addr / ADDR_W'(INST_BYTES);
  endfunction

endpackage

// File: rtl/hatch_if.sv
// CPU-side and memory-side signals of the fetch unit.
// The fetch unit connects through the slave modport; the CPU/memory side uses master.
interface hatch_if;
  import hatch_pkg::*;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] hatch_instruction;
  logic [ADDR_W-1:0] hatch_address;
  logic              fetch_fault;
  logic              mem_en;
  logic [7:0]        mem_index;
  logic [INST_W-1:0] mem_data;

  modport master (
    output redirect, redirect_addr, inst_ready, mem_data,
    input  inst_valid, hatch_instruction, hatch_address, fetch_fault, mem_en, mem_index
  );

  modport slave (
    input  redirect, redirect_addr, inst_ready, mem_data,
    output inst_valid, hatch_instruction, hatch_address, fetch_fault, mem_en, mem_index
  );

endinterface

// File: rtl/hatch_fifo.sv
// Synchronous FIFO with single-cycle flush; head is read straight from storage.
// The caller guarantees no push into a full FIFO without a simultaneous pop.
module hatch_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // NOTE: storage has no reset; count alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_b || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign valid = (count != '0);
  assign head  = store[rd_ptr];

endmodule

// File: rtl/hatch_fetch.sv
// Instruction prefetcher: streams 48-bit words from a synchronous memory into a
// small FIFO, handles CPU redirects, and halts with a fault past the end of memory.
module hatch_fetch
  import hatch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_WORDS = 256
) (
  input  logic   clk,
  input  logic   rst_b,
  hatch_if.slave bus
);

  localparam int                CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0]       DEPTH_W   = (CW + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] fetch_idx;
  logic [ADDR_W-1:0] pend_addr;
  logic              pending;
  logic              credit;
  logic              out_of_range;
  logic              push;
  logic              pop;
  logic              fifo_valid;
  logic [CW-1:0]     fifo_count;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign fetch_idx    = div6(pc);
  assign out_of_range = fetch_idx >= MEM_LIMIT;
  // Entries already stored plus the one read in flight must leave room for another.
  assign credit       = ({1'b0, fifo_count} + {{CW{1'b0}}, pending}) < DEPTH_W;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_b) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.redirect)                               state_next = RUN;
    else if (state == RUN && credit && out_of_range) state_next = FAULT;
  end

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    bus.mem_en      = 1'b0;
    bus.fetch_fault = 1'b0;
    case (state)
      RUN:     bus.mem_en = rst_b && !bus.redirect && credit && !out_of_range;
      FAULT:   bus.fetch_fault = 1'b1;
      default: ;
    endcase
  end

  // A redirect drops the outstanding read so its returning data is never pushed.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      pc        <= RESET_PC;
      pending   <= 1'b0;
      pend_addr <= '0;
    end else if (bus.redirect) begin
      pc      <= bus.redirect_addr;
      pending <= 1'b0;
    end else begin
      pending <= bus.mem_en;
      if (bus.mem_en) begin
        pc        <= pc + ADDR_W'(INST_BYTES);
        pend_addr <= fetch_idx * ADDR_W'(INST_BYTES);
      end
    end
  end

  assign push            = pending && !bus.redirect;
  assign pop             = fifo_valid && bus.inst_ready && !bus.redirect;
  assign push_entry.addr = pend_addr;
  assign push_entry.inst = bus.mem_data;

  hatch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .flush     (bus.redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .valid     (fifo_valid),
    .head      (head),
    .count     (fifo_count)
  );

  assign bus.inst_valid        = fifo_valid;
  assign bus.hatch_instruction = head.inst;
  assign bus.hatch_address     = head.addr;
  assign bus.mem_index         = fetch_idx[7:0];

endmodule

// File: tb/tb_hatch_fetch.sv
// Self-checking bench for hatch_fetch: a memory model plus a delivered-stream
// recorder, with expected streams derived from start word index and memory contents.
module tb_hatch_fetch;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  hatch_if bus ();

  hatch_fetch #(
    .DEPTH     (4),
    .RESET_PC  (32'd0),
    .MEM_WORDS (256)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  logic [47:0] mem [256];
  logic [31:0] got_addr [$];
  logic [47:0] got_data [$];
  int          mem_en_cnt = 0;
  int          checks     = 0;
  int          failures   = 0;

  // Synchronous memory: data one cycle after mem_en, junk otherwise.
  always @(posedge clk)
    bus.mem_data <= bus.mem_en ? mem[bus.mem_index] : 48'({$urandom, $urandom});

  // Records every accepted instruction and counts issued reads.
  always @(negedge clk) begin
    if (rst_b && bus.inst_valid && bus.inst_ready && !bus.redirect) begin
      got_addr.push_back(bus.hatch_address);
      got_data.push_back(bus.hatch_instruction);
    end
    if (bus.mem_en === 1'b1) mem_en_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] addr);
    bus.redirect      = 1'b1;
    bus.redirect_addr = addr;
    tick();
    bus.redirect = 1'b0;
  endtask

  task automatic test_reset();
    rst_b             = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;
    bus.inst_ready    = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = 48'(k);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid);
    end
    checks++;
    if (bus.mem_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_mem_en: got %b want 0", bus.mem_en);
    end
    checks++;
    if (bus.fetch_fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_fetch_fault: got %b want 0", bus.fetch_fault);
    end
    tick();
    rst_b          = 1'b1;
    bus.inst_ready = 1'b1;
  endtask

  task automatic test_stream();
    int base = got_addr.size();
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_index !== 8'd0 || bus.inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_cycle1: mem_en=%b index=%0d valid=%b want 1/0/0", bus.mem_en, bus.mem_index, bus.inst_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_cycle2_valid: got %b want 0", bus.inst_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b1) begin
      failures++;
      $display("FAIL stream_cycle3_valid: got %b want 1", bus.inst_valid);
    end
    repeat (20) tick();
    bus.inst_ready = 1'b0;
    checks++;
    if (got_addr.size() - base != 20) begin
      failures++;
      $display("FAIL stream_count: got %0d want 20", got_addr.size() - base);
    end
    for (int i = 0; i < got_addr.size() - base; i++) begin
      checks++;
      if (got_addr[base+i] !== 32'(i * 6) || got_data[base+i] !== 48'(i)) begin
        failures++;
        $display("FAIL stream[%0d]: got addr=%0d data=%h want addr=%0d data=%h", i, got_addr[base+i], got_data[base+i], i * 6, i);
      end
    end
  endtask

  task automatic test_backpressure();
    int s    = int'($urandom_range(0, 200));
    int base = got_addr.size();
    int e0   = mem_en_cnt;
    bus.inst_ready = 1'b0;
    do_redirect(32'(s * 6));
    repeat (20) tick();
    checks++;
    if (mem_en_cnt - e0 != 4) begin
      failures++;
      $display("FAIL bp_reads: got %0d want 4", mem_en_cnt - e0);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b0 || bus.inst_valid !== 1'b1 || got_addr.size() != base) begin
      failures++;
      $display("FAIL bp_hold: mem_en=%b valid=%b delivered=%0d want 0/1/0", bus.mem_en, bus.inst_valid, got_addr.size() - base);
    end
    tick();
    bus.inst_ready = 1'b1;
    repeat (15) tick();
    bus.inst_ready = 1'b0;
    checks++;
    if (got_addr.size() - base != 15) begin
      failures++;
      $display("FAIL bp_count: got %0d want 15", got_addr.size() - base);
    end
    for (int i = 0; i < got_addr.size() - base; i++) begin
      checks++;
      if (got_addr[base+i] !== 32'((s + i) * 6) || got_data[base+i] !== mem[s+i]) begin
        failures++;
        $display("FAIL bp[%0d]: got addr=%0d data=%h want addr=%0d data=%h", i, got_addr[base+i], got_data[base+i], (s + i) * 6, mem[s+i]);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    int s    = int'($urandom_range(0, 80));
    int n    = int'($urandom_range(3, 10));
    int base = got_addr.size();
    bus.inst_ready = 1'b1;
    do_redirect(32'(s * 6));
    repeat (n) tick();
    checks++;
    if (got_addr.size() - base != n - 2) begin
      failures++;
      $display("FAIL pre_redirect_count: got %0d want %0d", got_addr.size() - base, n - 2);
    end
    for (int i = 0; i < got_addr.size() - base; i++) begin
      checks++;
      if (got_addr[base+i] !== 32'((s + i) * 6) || got_data[base+i] !== mem[s+i]) begin
        failures++;
        $display("FAIL pre_redirect[%0d]: got addr=%0d data=%h want addr=%0d data=%h", i, got_addr[base+i], got_data[base+i], (s + i) * 6, mem[s+i]);
      end
    end
    base = got_addr.size();
    do_redirect(32'd600);
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_index !== 8'd100 || bus.inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_n1: mem_en=%b index=%0d valid=%b want 1/100/0", bus.mem_en, bus.mem_index, bus.inst_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_n2_valid: got %b want 0", bus.inst_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.hatch_address !== 32'd600 || bus.hatch_instruction !== mem[100]) begin
      failures++;
      $display("FAIL redirect_n3: valid=%b addr=%0d data=%h want 1/600/%h", bus.inst_valid, bus.hatch_address, bus.hatch_instruction, mem[100]);
    end
    repeat (10) tick();
    checks++;
    if (got_addr.size() - base != 10) begin
      failures++;
      $display("FAIL post_redirect_count: got %0d want 10", got_addr.size() - base);
    end
    for (int i = 0; i < got_addr.size() - base; i++) begin
      checks++;
      if (got_addr[base+i] !== 32'((100 + i) * 6) || got_data[base+i] !== mem[100+i]) begin
        failures++;
        $display("FAIL post_redirect[%0d]: got addr=%0d data=%h want addr=%0d data=%h", i, got_addr[base+i], got_data[base+i], (100 + i) * 6, mem[100+i]);
      end
    end
  endtask

  task automatic test_redirect_full();
    int a    = int'($urandom_range(0, 150));
    int b    = int'($urandom_range(0, 200));
    int off  = int'($urandom_range(0, 5));
    int base = got_addr.size();
    bus.inst_ready = 1'b0;
    do_redirect(32'(a * 6));
    repeat (8) tick();
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.mem_en !== 1'b0 || got_addr.size() != base) begin
      failures++;
      $display("FAIL full_before: valid=%b mem_en=%b delivered=%0d want 1/0/0", bus.inst_valid, bus.mem_en, got_addr.size() - base);
    end
    tick();
    bus.inst_ready = 1'b1;
    do_redirect(32'(b * 6 + off));
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b0 || got_addr.size() != base) begin
      failures++;
      $display("FAIL full_flush: valid=%b delivered=%0d want 0/0", bus.inst_valid, got_addr.size() - base);
    end
    repeat (12) tick();
    checks++;
    if (got_addr.size() - base != 10) begin
      failures++;
      $display("FAIL full_count: got %0d want 10", got_addr.size() - base);
    end
    for (int i = 0; i < got_addr.size() - base; i++) begin
      checks++;
      if (got_addr[base+i] !== 32'((b + i) * 6) || got_data[base+i] !== mem[b+i]) begin
        failures++;
        $display("FAIL full_target[%0d]: got addr=%0d data=%h want addr=%0d data=%h", i, got_addr[base+i], got_data[base+i], (b + i) * 6, mem[b+i]);
      end
    end
  endtask

  task automatic test_fault();
    int base = got_addr.size();
    int e0   = mem_en_cnt;
    // Three words remain before the end, so the fault is reached with entries still queued.
    bus.inst_ready = 1'b0;
    do_redirect(32'd1518);
    repeat (8) tick();
    @(negedge clk);
    checks++;
    if (bus.fetch_fault !== 1'b1 || bus.inst_valid !== 1'b1 || bus.mem_en !== 1'b0 || mem_en_cnt - e0 != 3) begin
      failures++;
      $display("FAIL fault_enter: fault=%b valid=%b mem_en=%b reads=%0d want 1/1/0/3", bus.fetch_fault, bus.inst_valid, bus.mem_en, mem_en_cnt - e0);
    end
    tick();
    bus.inst_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (got_addr.size() - base != 3 || bus.fetch_fault !== 1'b1) begin
      failures++;
      $display("FAIL fault_drain: delivered=%0d fault=%b want 3/1", got_addr.size() - base, bus.fetch_fault);
    end
    for (int i = 0; i < got_addr.size() - base; i++) begin
      checks++;
      if (got_addr[base+i] !== 32'((253 + i) * 6) || got_data[base+i] !== mem[253+i]) begin
        failures++;
        $display("FAIL fault_drain[%0d]: got addr=%0d data=%h want addr=%0d data=%h", i, got_addr[base+i], got_data[base+i], (253 + i) * 6, mem[253+i]);
      end
    end
    base = got_addr.size();
    e0   = mem_en_cnt;
    do_redirect(32'd1530);
    repeat (8) tick();
    @(negedge clk);
    checks++;
    if (bus.fetch_fault !== 1'b1 || mem_en_cnt - e0 != 1 || got_addr.size() - base != 1) begin
      failures++;
      $display("FAIL fault_last_word: fault=%b reads=%0d delivered=%0d want 1/1/1", bus.fetch_fault, mem_en_cnt - e0, got_addr.size() - base);
    end else begin
      checks++;
      if (got_addr[base] !== 32'd1530 || got_data[base] !== mem[255]) begin
        failures++;
        $display("FAIL fault_word255: got addr=%0d data=%h want addr=1530 data=%h", got_addr[base], got_data[base], mem[255]);
      end
    end
    tick();
    base = got_addr.size();
    do_redirect(32'd0);
    @(negedge clk);
    checks++;
    if (bus.fetch_fault !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_index !== 8'd0) begin
      failures++;
      $display("FAIL fault_clear: fault=%b mem_en=%b index=%0d want 0/1/0", bus.fetch_fault, bus.mem_en, bus.mem_index);
    end
    repeat (6) tick();
    checks++;
    if (got_addr.size() - base != 4) begin
      failures++;
      $display("FAIL fault_restart_count: got %0d want 4", got_addr.size() - base);
    end
    for (int i = 0; i < got_addr.size() - base; i++) begin
      checks++;
      if (got_addr[base+i] !== 32'(i * 6) || got_data[base+i] !== mem[i]) begin
        failures++;
        $display("FAIL fault_restart[%0d]: got addr=%0d data=%h want addr=%0d data=%h", i, got_addr[base+i], got_data[base+i], i * 6, mem[i]);
      end
    end
  endtask

  task automatic test_midreset();
    int s = int'($urandom_range(0, 100));
    int n = int'($urandom_range(4, 12));
    int base;
    bus.inst_ready = 1'b1;
    do_redirect(32'(s * 6));
    repeat (n) tick();
    rst_b = 1'b0;
    base  = got_addr.size();
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b0) begin
      failures++;
      $display("FAIL midreset_mem_en: got %b want 0", bus.mem_en);
    end
    tick();
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.fetch_fault !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_index !== 8'd0) begin
      failures++;
      $display("FAIL midreset_cycle1: valid=%b fault=%b mem_en=%b index=%0d want 0/0/1/0", bus.inst_valid, bus.fetch_fault, bus.mem_en, bus.mem_index);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_cycle2_valid: got %b want 0", bus.inst_valid);
    end
    repeat (8) tick();
    checks++;
    if (got_addr.size() - base != 7) begin
      failures++;
      $display("FAIL midreset_count: got %0d want 7", got_addr.size() - base);
    end
    for (int i = 0; i < got_addr.size() - base; i++) begin
      checks++;
      if (got_addr[base+i] !== 32'(i * 6) || got_data[base+i] !== mem[i]) begin
        failures++;
        $display("FAIL midreset[%0d]: got addr=%0d data=%h want addr=%0d data=%h", i, got_addr[base+i], got_data[base+i], i * 6, mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    for (int k = 0; k < 256; k++) mem[k] = 48'({$urandom, $urandom});
    test_backpressure();
    test_redirect_inflight();
    test_redirect_full();
    test_fault();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
